// File: rtl/sp_ram_burst_master.sv
// Burst initiator for a single-port RAM: walks sequential word addresses,
// sourcing write beats from a stream or returning reads through a 2-entry FIFO.
module sp_ram_burst_master #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 13,
    localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [BE_WIDTH-1:0]   wr_be_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    output logic [BE_WIDTH-1:0]   ram_be_o,
    output logic                  ram_bypass_en_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            count_q, count_d;
    logic                  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic [DATA_WIDTH-1:0] fifo_d [2];

    logic       wr_beat_s, rd_issue_s, pop_s, push_s;
    logic [2:0] credit_s;

    // Handshake decode; a read issues only if its word is guaranteed a FIFO slot
    always_comb begin
        pop_s      = (count_q != 2'd0) && rd_ready_i;
        push_s     = inflight_q;
        credit_s   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        wr_beat_s  = (state_q == S_WR) && wr_valid_i;
        rd_issue_s = (state_q == S_RD) && (credit_s < 3'd2);
    end

    // Next-state, address/count and FIFO update
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        inflight_d = rd_issue_s;
        count_d    = count_q + {1'b0, push_s} - {1'b0, pop_s};
        wptr_d     = wptr_q ^ push_s;
        rptr_d     = rptr_q ^ pop_s;
        fifo_d     = fifo_q;
        if (push_s) begin
            fifo_d[wptr_q] = ram_rdata_i;
        end else begin
            fifo_d[wptr_q] = fifo_q[wptr_q];
        end
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    addr_d   = cmd_addr_i & ~ADDR_WIDTH'(BE_WIDTH - 1);
                    remain_d = cmd_len_i;
                    if (cmd_len_i == '0) begin
                        state_d = S_DONE;
                    end else if (cmd_write_i) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR, S_RD: begin
                if (wr_beat_s || rd_issue_s) begin
                    addr_d   = addr_q + ADDR_WIDTH'(BE_WIDTH);
                    remain_d = remain_q - LEN_WIDTH'(1);
                    if (remain_q == LEN_WIDTH'(1)) begin
                        state_d = (state_q == S_WR) ? S_DONE : S_DRAIN;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_DRAIN: begin
                if (!inflight_q && ((count_q - {1'b0, pop_s}) == 2'd0)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fifo_q[0]  <= fifo_d[0];
            fifo_q[1]  <= fifo_d[1];
        end
    end

    // Output decode; write data and enables pass straight through during WR
    always_comb begin
        cmd_ready_o     = (state_q == S_IDLE);
        wr_ready_o      = (state_q == S_WR);
        busy_o          = (state_q != S_IDLE);
        done_o          = (state_q == S_DONE);
        rd_valid_o      = (count_q != 2'd0);
        rd_data_o       = fifo_q[rptr_q];
        ram_en_o        = wr_beat_s || rd_issue_s;
        ram_we_o        = wr_beat_s;
        ram_addr_o      = addr_q;
        ram_bypass_en_o = 1'b0;
        if (state_q == S_WR) begin
            ram_wdata_o = wr_data_i;
            ram_be_o    = wr_be_i;
        end else if (rd_issue_s) begin
            ram_wdata_o = '0;
            ram_be_o    = '1;
        end else begin
            ram_wdata_o = '0;
            ram_be_o    = '0;
        end
    end

endmodule

// File: doc/sp_ram_burst_master.md
# sp_ram_burst_master

Burst initiator for the single-port RAM wrapper port (en/addr/wdata/we/be in, rdata out one cycle after an enabled read). It accepts one command at a time: a word-aligned base byte address, a word count and a direction. It then issues sequential RAM accesses, taking write data from a valid/ready stream or returning read data on a valid/ready stream. It sits between a loader, DMA or debug agent and the instruction/data RAM, and handles read back-pressure with a 2-entry output buffer.

## Interface
- ADDR_WIDTH, 15: byte address width of the RAM port (32 KiB).
- DATA_WIDTH, 32: word width; BE_WIDTH = DATA_WIDTH/8.
- LEN_WIDTH, 13: width of the word-count field.

Clocking and reset: one clock; reset is synchronous and active-high.

Ports:
- clk  in  1  clock
- rst_i  in  1  synchronous reset, active high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid & ready
- cmd_write_i  in  1  1 = write burst, 0 = read burst
- cmd_addr_i  in  ADDR_WIDTH  base byte address; bits [1:0] ignored (treated as 0)
- cmd_len_i  in  LEN_WIDTH  number of words; 0 allowed
- wr_valid_i / wr_ready_o  in / out  1  write-data handshake
- wr_data_i  in  DATA_WIDTH  write word
- wr_be_i  in  BE_WIDTH  byte enables for that word
- rd_valid_o / rd_ready_i  out / in  1  read-data handshake
- rd_data_o  out  DATA_WIDTH  read word
- busy_o  out  1  high whenever state is not IDLE
- done_o  out  1  one-cycle pulse when the burst completes
- ram_en_o, ram_we_o  out  1  RAM enable and write enable
- ram_addr_o  out  ADDR_WIDTH  RAM byte address, [1:0] = 0
- ram_wdata_o  out  DATA_WIDTH  RAM write data
- ram_be_o  out  BE_WIDTH  RAM byte enables
- ram_bypass_en_o  out  1  constant 0
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after a read enable

## Operation
States: IDLE, WR, RD, DRAIN, DONE.

IDLE
- cmd_ready_o = 1.
- On accept: latch address (with [1:0] cleared), remaining = cmd_len_i, and direction.
- len = 0 goes to DONE; otherwise go to WR or RD.

WR
- wr_ready_o = 1.
- ram_en_o = ram_we_o = wr_valid_i.
- ram_wdata_o / ram_be_o are driven combinationally from wr_data_i / wr_be_i.
- Each accepted beat: address += BE_WIDTH, remaining -= 1.
- After the last beat, go to DONE.
- wr_ready_o = 0 in every other state.

RD
- Issue a read (ram_en_o = 1, ram_we_o = 0, ram_be_o = all ones) when `fifo_count + inflight - (rd_valid_o & rd_ready_i) < 2`.
- inflight is a 1-bit register set on issue. ram_rdata_i is pushed into the 2-entry FIFO in the following cycle.
- Each issue: address += BE_WIDTH, remaining -= 1.
- After the last issue, go to DRAIN.

DRAIN
- No RAM access.
- Go to DONE when inflight = 0, the FIFO is empty after this cycle's pop, and no push is pending.

DONE
- done_o = 1 and cmd_ready_o = 0 for exactly one cycle, then IDLE.

General rules
- Address arithmetic is modulo 2^ADDR_WIDTH: 0x7FFC + 4 wraps to 0x0000.
- rd_data_o is the FIFO head. The FIFO is never written when full; the credit rule guarantees this.
- ram_en_o = 0 in IDLE, DRAIN and DONE. ram_addr_o holds the current address in all states.

Reset, including mid-burst
- State goes to IDLE; FIFO and inflight are cleared; the remaining count is dropped.
- A read returning in the cycle after reset is discarded.
- A write burst cut by reset leaves earlier words written and later words not written.

## Timing
- Reset values: cmd_ready_o = 1 after reset. rd_valid_o, wr_ready_o, busy_o, done_o, ram_en_o, ram_we_o and ram_bypass_en_o are 0. ram_addr_o, ram_be_o and rd_data_o are 0.
- Command accepted in cycle N: busy_o = 1 and the first RAM access can occur in N+1.
- Read path: issue in cycle t, data captured into the FIFO at the end of t+1, rd_valid_o in t+2. Sustained throughput is 1 word/cycle while rd_ready_i = 1.
- Write path: one word per cycle while wr_valid_i = 1. The RAM write occurs at the edge ending the cycle in which the beat is accepted.
- len = 0: accepted in N, done_o in N+1, no RAM access.
- Last write beat accepted in cycle M: done_o in M+1.
- Last read word popped in cycle M: done_o in M+1.
- cmd_valid_i is ignored while busy_o = 1.

## Test plan
- Reset check: assert rst_i for 3 cycles, including once mid-read → all outputs at the reset values above; no rd_valid_o afterwards.
- Write then read back: write len 4 at 0x0010 with data 0xA0..0xA3 and be = 0xF, then read len 4 at 0x0010 with rd_ready_i = 1 → ram_addr_o steps 0x10, 0x14, 0x18, 0x1C; data returns A0..A3 on consecutive cycles; each done_o is exactly 1 cycle.
- Back-pressure: read len 8 with rd_ready_i low for cycles 3–8 → at most 2 words buffered; no RAM issue while stalled; all 8 words delivered in order with none lost or duplicated.
- Byte enables and wrap: write at 0x7FFC len 2 with be 0x3 then 0xC → accesses at 0x7FFC then 0x0000 with matching ram_be_o; read back confirms only the enabled bytes changed.
- Zero length and ignored command: cmd_len_i = 0 → done_o in the next cycle with ram_en_o never high. A second cmd_valid_i pulsed during a busy burst is not accepted.
- Write stall: wr_valid_i toggles 1, 0, 0, 1, 1 for len 3 → ram_en_o mirrors wr_valid_i; exactly 3 RAM writes; done_o follows the third write.
